vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter DIV, default 4: system clocks per pixel (100 MHz clk gives a 25 MHz pixel rate).
REQ-002 SHALL have parameters HD=640, HF=16, HS=96, HB=48: horizontal display, front porch, sync and back porch widths, in pixels.
REQ-003 SHALL have parameters VD=480, VF=10, VS=2, VB=33: vertical display, front porch, sync and back porch heights, in lines.
REQ-004 SHALL have port clk, input, 1 bit: sole clock; all state SHALL change on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-006 SHALL have port hsync, output, 1 bit: horizontal sync, active-low.
REQ-007 SHALL have port vsync, output, 1 bit: vertical sync, active-low.
REQ-008 SHALL have port video_on, output, 1 bit: high only while the current pixel is inside the HD x VD region.
REQ-009 SHALL have port p_tick, output, 1 bit: one-clk pixel strobe.
REQ-010 SHALL have ports pix_x and pix_y, outputs, 10 bits each: current horizontal and vertical counts, consumed by the screen overlay blocks.
REQ-011 SHALL have port frame_start, output, 1 bit: one-clk pulse marking entry to pixel (0,0).
REQ-012 SHALL have port line_end, output, 1 bit: one-clk pulse on the last pixel of each line.

Function
REQ-013 SHALL hold a prescaler div_cnt counting 0..DIV-1 and wrapping to 0.
REQ-014 SHALL assert p_tick in exactly the clk cycle where div_cnt==DIV-1; p_tick SHALL therefore be high 1 cycle in every DIV.
REQ-015 SHALL advance h_cnt only on clk edges where p_tick=1; h_cnt SHALL wrap from HT-1 to 0, where HT=HD+HF+HS+HB=800.
REQ-016 SHALL advance v_cnt only on edges where p_tick=1 and h_cnt==HT-1; v_cnt SHALL wrap from VT-1 to 0, where VT=VD+VF+VS+VB=525.
REQ-017 SHALL drive pix_x=h_cnt and pix_y=v_cnt directly from registers, with no combinational path from inputs.
REQ-018 SHALL register hsync, vsync and video_on from the next-state counter values, so that each is aligned in the same cycle with the pix_x/pix_y it describes.
REQ-019 SHALL drive hsync=0 iff HD+HF <= pix_x <= HD+HF+HS-1 (656..751).
REQ-020 SHALL drive vsync=0 iff VD+VF <= pix_y <= VD+VF+VS-1 (490..491).
REQ-021 SHALL drive video_on=1 iff pix_x<HD and pix_y<VD.
REQ-022 SHALL pulse line_end when p_tick=1 and h_cnt==HT-1.
REQ-023 SHALL pulse frame_start in the cycle following the edge on which counters wrap to (0,0); this is 1 clk per frame.
REQ-024 SHALL produce a frame period of exactly HT*VT*DIV clocks (1,680,000 at defaults) and a line period of HT*DIV clocks (3,200).
REQ-025 SHALL hold pix_x/pix_y constant for DIV consecutive clocks; downstream 1-clk registered overlays depend on this.

Reset
REQ-026 SHALL, while reset=0 on a clk edge, load: div_cnt=0, h_cnt=0, v_cnt=0, hsync=1, vsync=1, video_on=0, p_tick=0, frame_start=0, line_end=0.
REQ-027 SHALL, on the first edge with reset=1, load video_on=1 and hsync=vsync=1 (pixel 0,0); no frame_start pulse SHALL follow reset.
REQ-028 SHALL abandon any partial line or frame when reset is asserted mid-frame; no illegal count (h>=HT, v>=VT) SHALL ever be reachable.

Verification
REQ-029 SHALL be verified by a reset-release check: hold reset=0 for 5 clks, then release -> pix_x=0, pix_y=0, video_on=1, hsync=vsync=1; p_tick first high 4 clks after release.
REQ-030 SHALL be verified by a horizontal-timing check: run 1 line -> hsync low for exactly 96*4=384 clks starting at pix_x=656; video_on falls when pix_x goes 639->640.
REQ-031 SHALL be verified by a vertical-timing check: run 1 frame -> vsync low for 2*800*4=6,400 clks starting at pix_y=490; line_end seen 525 times.
REQ-032 SHALL be verified by a frame-period check: measure between frame_start pulses -> exactly 1,680,000 clks, with pix_x/pix_y never exceeding 799/524.
REQ-033 SHALL be verified by a mid-frame reset check: assert reset at pix_x=700, pix_y=300 for 1 clk -> next cycle pix_x=0, pix_y=0, vsync=1, hsync=1, video_on=0; timing resumes per REQ-027.
REQ-034 SHALL be verified by a parameter check: DIV=2, defaults otherwise -> p_tick every 2 clks, frame period 840,000 clks.

Source files
------------

// File: rtl/vga_sync_if.sv
// Raster timing bundle from the sync generator to display and overlay logic.
// No valid/ready: p_tick, frame_start and line_end are one-clk strobes and every level is registered.
interface vga_sync_if;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic       p_tick;
   logic       frame_start;
   logic       line_end;
   logic [9:0] pix_x;
   logic [9:0] pix_y;

   modport master (
      output hsync, vsync, video_on, p_tick, frame_start, line_end, pix_x, pix_y
   );

   modport slave (
      input hsync, vsync, video_on, p_tick, frame_start, line_end, pix_x, pix_y
   );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing: prescaled pixel strobe, h/v counters, and registered syncs/strobes
// aligned cycle-for-cycle with the pixel coordinates they describe.
module vga_sync_gen #(
   parameter int DIV = 4,
   parameter int HD  = 640,
   parameter int HF  = 16,
   parameter int HS  = 96,
   parameter int HB  = 48,
   parameter int VD  = 480,
   parameter int VF  = 10,
   parameter int VS  = 2,
   parameter int VB  = 33
) (
   input  logic       clk,
   input  logic       reset,
   vga_sync_if.master vga
);
   localparam int HT = HD + HF + HS + HB;
   localparam int VT = VD + VF + VS + VB;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [9:0]    H_LAST   = 10'(HT - 1);
   localparam logic [9:0]    V_LAST   = 10'(VT - 1);
   localparam logic [9:0]    H_DISP   = 10'(HD);
   localparam logic [9:0]    V_DISP   = 10'(VD);
   localparam logic [9:0]    HS_FIRST = 10'(HD + HF);
   localparam logic [9:0]    HS_LAST  = 10'(HD + HF + HS - 1);
   localparam logic [9:0]    VS_FIRST = 10'(VD + VF);
   localparam logic [9:0]    VS_LAST  = 10'(VD + VF + VS - 1);

   logic [DW-1:0] div_cnt, div_nxt;
   logic [9:0]    h_cnt, h_nxt;
   logic [9:0]    v_cnt, v_nxt;
   logic          tick_nxt, line_wrap;
   logic          p_tick_r, hsync_r, vsync_r, video_on_r, frame_start_r, line_end_r;

   // Range compares (>=) keep any out-of-range count from surviving past one step.
   always_comb begin
      div_nxt   = (div_cnt >= DIV_LAST) ? '0 : div_cnt + 1'b1;
      tick_nxt  = (div_nxt == DIV_LAST);
      line_wrap = p_tick_r && (h_cnt >= H_LAST);
      h_nxt     = h_cnt;
      v_nxt     = v_cnt;
      if (p_tick_r) h_nxt = line_wrap ? '0 : h_cnt + 10'd1;
      if (line_wrap) v_nxt = (v_cnt >= V_LAST) ? '0 : v_cnt + 10'd1;
   end

   // Outputs are decoded from next-state counts so they land with the matching pix_x/pix_y.
   always_ff @(posedge clk) begin
      if (!reset) begin
         div_cnt       <= '0;
         h_cnt         <= '0;
         v_cnt         <= '0;
         p_tick_r      <= 1'b0;
         hsync_r       <= 1'b1;
         vsync_r       <= 1'b1;
         video_on_r    <= 1'b0;
         frame_start_r <= 1'b0;
         line_end_r    <= 1'b0;
      end else begin
         div_cnt       <= div_nxt;
         h_cnt         <= h_nxt;
         v_cnt         <= v_nxt;
         p_tick_r      <= tick_nxt;
         hsync_r       <= !((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST));
         vsync_r       <= !((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST));
         video_on_r    <= (h_nxt < H_DISP) && (v_nxt < V_DISP);
         line_end_r    <= tick_nxt && (h_nxt == H_LAST);
         frame_start_r <= line_wrap && (v_cnt >= V_LAST);
      end
   end

   assign vga.pix_x       = h_cnt;
   assign vga.pix_y       = v_cnt;
   assign vga.p_tick      = p_tick_r;
   assign vga.hsync       = hsync_r;
   assign vga.vsync       = vsync_r;
   assign vga.video_on    = video_on_r;
   assign vga.frame_start = frame_start_r;
   assign vga.line_end    = line_end_r;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed checks of vga_sync_gen: default-timing DUT for reset and line timing, plus
// two small-geometry DUTs (HT=25, VT=13) so whole frames fit in a short run.
module tb_vga_sync_gen;
   logic clk = 1'b0;
   logic rst_d, rst_s, rst_2;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [9:0] exp_q[$];

   always #5 clk = ~clk;

   vga_sync_if d_if ();
   vga_sync_if s_if ();
   vga_sync_if t_if ();

   vga_sync_gen u_def (.clk(clk), .reset(rst_d), .vga(d_if));

   vga_sync_gen #(.DIV(4), .HD(16), .HF(2), .HS(4), .HB(3),
                  .VD(6), .VF(2), .VS(2), .VB(3)) u_sml (.clk(clk), .reset(rst_s), .vga(s_if));

   vga_sync_gen #(.DIV(2), .HD(16), .HF(2), .HS(4), .HB(3),
                  .VD(6), .VF(2), .VS(2), .VB(3)) u_div2 (.clk(clk), .reset(rst_2), .vga(t_if));

   task automatic test_reset();
      int first_tick = 0;
      int fs_seen = 0;
      rst_d = 1'b0; rst_s = 1'b0; rst_2 = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++; if (d_if.pix_x !== 10'd0) begin n_fail++; $display("FAIL rst_pix_x: got %0d, expected 0", d_if.pix_x); end
      n_checks++; if (d_if.pix_y !== 10'd0) begin n_fail++; $display("FAIL rst_pix_y: got %0d, expected 0", d_if.pix_y); end
      n_checks++; if (d_if.hsync !== 1'b1) begin n_fail++; $display("FAIL rst_hsync: got %b, expected 1", d_if.hsync); end
      n_checks++; if (d_if.vsync !== 1'b1) begin n_fail++; $display("FAIL rst_vsync: got %b, expected 1", d_if.vsync); end
      n_checks++; if (d_if.video_on !== 1'b0) begin n_fail++; $display("FAIL rst_video_on: got %b, expected 0", d_if.video_on); end
      n_checks++; if (d_if.p_tick !== 1'b0) begin n_fail++; $display("FAIL rst_p_tick: got %b, expected 0", d_if.p_tick); end
      n_checks++; if (d_if.frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_frame_start: got %b, expected 0", d_if.frame_start); end
      n_checks++; if (d_if.line_end !== 1'b0) begin n_fail++; $display("FAIL rst_line_end: got %b, expected 0", d_if.line_end); end
      n_checks++; if (s_if.video_on !== 1'b0) begin n_fail++; $display("FAIL rst_sml_video_on: got %b, expected 0", s_if.video_on); end
      rst_d = 1'b1;
      @(negedge clk);
      n_checks++; if (d_if.pix_x !== 10'd0) begin n_fail++; $display("FAIL rel_pix_x: got %0d, expected 0", d_if.pix_x); end
      n_checks++; if (d_if.pix_y !== 10'd0) begin n_fail++; $display("FAIL rel_pix_y: got %0d, expected 0", d_if.pix_y); end
      n_checks++; if (d_if.video_on !== 1'b1) begin n_fail++; $display("FAIL rel_video_on: got %b, expected 1", d_if.video_on); end
      n_checks++; if (d_if.hsync !== 1'b1) begin n_fail++; $display("FAIL rel_hsync: got %b, expected 1", d_if.hsync); end
      n_checks++; if (d_if.vsync !== 1'b1) begin n_fail++; $display("FAIL rel_vsync: got %b, expected 1", d_if.vsync); end
      n_checks++; if (d_if.p_tick !== 1'b0) begin n_fail++; $display("FAIL rel_p_tick: got %b, expected 0", d_if.p_tick); end
      // div_cnt runs 0,1,2,3 from the reset-loaded cycle, so p_tick fills the 4th clk period.
      for (int k = 2; k <= 8; k++) begin
         @(negedge clk);
         if (d_if.frame_start) fs_seen = 1;
         if (d_if.p_tick) begin first_tick = k; break; end
      end
      n_checks++; if (first_tick != 3) begin n_fail++; $display("FAIL first_p_tick: got negedge %0d, expected 3", first_tick); end
      n_checks++; if (fs_seen != 0) begin n_fail++; $display("FAIL no_fs_after_reset: got %0d, expected 0", fs_seen); end
   endtask

   task automatic test_pixel_hold();
      logic [9:0] exp_x;
      logic       exp_tick;
      for (int i = 1; i <= 40; i++) exp_q.push_back(10'((i + 3) / 4));
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         exp_x    = exp_q.pop_front();
         exp_tick = ((i % 4) == 0);
         n_checks++; if (d_if.pix_x !== exp_x) begin n_fail++; $display("FAIL hold_pix_x[%0d]: got %0d, expected %0d", i, d_if.pix_x, exp_x); end
         n_checks++; if (d_if.p_tick !== exp_tick) begin n_fail++; $display("FAIL hold_p_tick[%0d]: got %b, expected %b", i, d_if.p_tick, exp_tick); end
      end
      n_checks++; if (d_if.pix_y !== 10'd0) begin n_fail++; $display("FAIL hold_pix_y: got %0d, expected 0", d_if.pix_y); end
   endtask

   task automatic test_horizontal();
      int found = 0, y0, hs_low = 0, hs_first_x = -1, vo_cnt = 0, vo_fell = 0;
      int vo_fall_x = -1, vo_prev_x = -1, prev_x = -1, le_cnt = 0, le_at = -1, y_moved = 0;
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         if (d_if.line_end) begin found = 1; break; end
      end
      n_checks++; if (found != 1) begin n_fail++; $display("FAIL h_line_end_timeout: got %0d, expected 1", found); end
      n_checks++; if (d_if.pix_x !== 10'd799) begin n_fail++; $display("FAIL h_line_end_x: got %0d, expected 799", d_if.pix_x); end
      @(negedge clk);
      y0 = int'(d_if.pix_y);
      n_checks++; if (d_if.pix_x !== 10'd0) begin n_fail++; $display("FAIL h_start_x: got %0d, expected 0", d_if.pix_x); end
      n_checks++; if (y0 != 1) begin n_fail++; $display("FAIL h_start_y: got %0d, expected 1", y0); end
      for (int c = 0; c < 3200; c++) begin
         if (!d_if.hsync) begin
            if (hs_low == 0) hs_first_x = int'(d_if.pix_x);
            hs_low++;
         end
         if (d_if.video_on) vo_cnt++;
         else if (vo_fell == 0) begin vo_fell = 1; vo_fall_x = int'(d_if.pix_x); vo_prev_x = prev_x; end
         if (d_if.line_end) begin le_cnt++; le_at = c; end
         if (int'(d_if.pix_y) != y0) y_moved++;
         prev_x = int'(d_if.pix_x);
         @(negedge clk);
      end
      n_checks++; if (hs_low != 384) begin n_fail++; $display("FAIL h_hsync_low_clks: got %0d, expected 384", hs_low); end
      n_checks++; if (hs_first_x != 656) begin n_fail++; $display("FAIL h_hsync_first_x: got %0d, expected 656", hs_first_x); end
      n_checks++; if (vo_cnt != 2560) begin n_fail++; $display("FAIL h_video_on_clks: got %0d, expected 2560", vo_cnt); end
      n_checks++; if (vo_fall_x != 640) begin n_fail++; $display("FAIL h_video_fall_x: got %0d, expected 640", vo_fall_x); end
      n_checks++; if (vo_prev_x != 639) begin n_fail++; $display("FAIL h_video_prev_x: got %0d, expected 639", vo_prev_x); end
      n_checks++; if (le_cnt != 1) begin n_fail++; $display("FAIL h_line_end_count: got %0d, expected 1", le_cnt); end
      n_checks++; if (le_at != 3199) begin n_fail++; $display("FAIL h_line_end_clk: got %0d, expected 3199", le_at); end
      n_checks++; if (y_moved != 0) begin n_fail++; $display("FAIL h_pix_y_stable: got %0d changes, expected 0", y_moved); end
      n_checks++; if (d_if.pix_x !== 10'd0) begin n_fail++; $display("FAIL h_next_x: got %0d, expected 0", d_if.pix_x); end
      n_checks++; if (int'(d_if.pix_y) != y0 + 1) begin n_fail++; $display("FAIL h_next_y: got %0d, expected %0d", d_if.pix_y, y0 + 1); end
   endtask

   task automatic test_vertical();
      int fs_at = 0, period = 0, vs_low = 0, vs_first_y = -1, vs_first_x = -1;
      int le_cnt = 0, hs_low = 0, vo_cnt = 0, maxx = 0, maxy = 0;
      rst_s = 1'b1;
      for (int k = 1; k <= 2000; k++) begin
         @(negedge clk);
         if (s_if.frame_start) begin fs_at = k; break; end
      end
      n_checks++; if (fs_at != 1300) begin n_fail++; $display("FAIL v_first_frame_start: got clk %0d, expected 1300", fs_at); end
      n_checks++; if (s_if.pix_x !== 10'd0 || s_if.pix_y !== 10'd0) begin n_fail++; $display("FAIL v_fs_origin: got (%0d,%0d), expected (0,0)", s_if.pix_x, s_if.pix_y); end
      n_checks++; if (s_if.video_on !== 1'b1) begin n_fail++; $display("FAIL v_fs_video_on: got %b, expected 1", s_if.video_on); end
      for (int c = 0; c < 3000; c++) begin
         if (c > 0 && s_if.frame_start) begin period = c; break; end
         if (!s_if.vsync) begin
            if (vs_low == 0) begin vs_first_y = int'(s_if.pix_y); vs_first_x = int'(s_if.pix_x); end
            vs_low++;
         end
         if (!s_if.hsync) hs_low++;
         if (s_if.video_on) vo_cnt++;
         if (s_if.line_end) le_cnt++;
         if (int'(s_if.pix_x) > maxx) maxx = int'(s_if.pix_x);
         if (int'(s_if.pix_y) > maxy) maxy = int'(s_if.pix_y);
         @(negedge clk);
      end
      n_checks++; if (period != 1300) begin n_fail++; $display("FAIL v_frame_period: got %0d, expected 1300", period); end
      n_checks++; if (vs_low != 200) begin n_fail++; $display("FAIL v_vsync_low_clks: got %0d, expected 200", vs_low); end
      n_checks++; if (vs_first_y != 8) begin n_fail++; $display("FAIL v_vsync_first_y: got %0d, expected 8", vs_first_y); end
      n_checks++; if (vs_first_x != 0) begin n_fail++; $display("FAIL v_vsync_first_x: got %0d, expected 0", vs_first_x); end
      n_checks++; if (le_cnt != 13) begin n_fail++; $display("FAIL v_line_end_count: got %0d, expected 13", le_cnt); end
      n_checks++; if (hs_low != 208) begin n_fail++; $display("FAIL v_hsync_low_clks: got %0d, expected 208", hs_low); end
      n_checks++; if (vo_cnt != 384) begin n_fail++; $display("FAIL v_video_on_clks: got %0d, expected 384", vo_cnt); end
      n_checks++; if (maxx != 24) begin n_fail++; $display("FAIL v_max_pix_x: got %0d, expected 24", maxx); end
      n_checks++; if (maxy != 12) begin n_fail++; $display("FAIL v_max_pix_y: got %0d, expected 12", maxy); end
   endtask

   task automatic test_mid_reset();
      int found = 0, fs_at = 0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (s_if.pix_x == 10'd20 && s_if.pix_y == 10'd9) begin found = 1; break; end
      end
      n_checks++; if (found != 1) begin n_fail++; $display("FAIL m_reach_20_9: got %0d, expected 1", found); end
      n_checks++; if (s_if.hsync !== 1'b0) begin n_fail++; $display("FAIL m_pre_hsync: got %b, expected 0", s_if.hsync); end
      n_checks++; if (s_if.vsync !== 1'b0) begin n_fail++; $display("FAIL m_pre_vsync: got %b, expected 0", s_if.vsync); end
      rst_s = 1'b0;
      @(negedge clk);
      n_checks++; if (s_if.pix_x !== 10'd0 || s_if.pix_y !== 10'd0) begin n_fail++; $display("FAIL m_rst_origin: got (%0d,%0d), expected (0,0)", s_if.pix_x, s_if.pix_y); end
      n_checks++; if (s_if.hsync !== 1'b1) begin n_fail++; $display("FAIL m_rst_hsync: got %b, expected 1", s_if.hsync); end
      n_checks++; if (s_if.vsync !== 1'b1) begin n_fail++; $display("FAIL m_rst_vsync: got %b, expected 1", s_if.vsync); end
      n_checks++; if (s_if.video_on !== 1'b0) begin n_fail++; $display("FAIL m_rst_video_on: got %b, expected 0", s_if.video_on); end
      n_checks++; if (s_if.line_end !== 1'b0 || s_if.frame_start !== 1'b0) begin n_fail++; $display("FAIL m_rst_strobes: got le=%b fs=%b, expected 0 0", s_if.line_end, s_if.frame_start); end
      rst_s = 1'b1;
      @(negedge clk);
      n_checks++; if (s_if.video_on !== 1'b1) begin n_fail++; $display("FAIL m_rel_video_on: got %b, expected 1", s_if.video_on); end
      for (int k = 2; k <= 2000; k++) begin
         @(negedge clk);
         if (s_if.frame_start) begin fs_at = k; break; end
      end
      n_checks++; if (fs_at != 1300) begin n_fail++; $display("FAIL m_frame_start_clk: got %0d, expected 1300", fs_at); end
   endtask

   task automatic test_div2();
      int fs_at = 0, ticks = 0, first_tick = 0, last_tick = 0, gap_err = 0, maxx = 0;
      rst_2 = 1'b1;
      for (int k = 1; k <= 1500; k++) begin
         @(negedge clk);
         if (t_if.p_tick) begin
            if (first_tick == 0) first_tick = k;
            if (last_tick != 0 && k - last_tick != 2) gap_err++;
            last_tick = k;
            ticks++;
         end
         if (int'(t_if.pix_x) > maxx) maxx = int'(t_if.pix_x);
         if (t_if.frame_start) begin fs_at = k; break; end
      end
      n_checks++; if (fs_at != 650) begin n_fail++; $display("FAIL d2_frame_period: got %0d, expected 650", fs_at); end
      n_checks++; if (ticks != 325) begin n_fail++; $display("FAIL d2_tick_count: got %0d, expected 325", ticks); end
      n_checks++; if (first_tick != 1) begin n_fail++; $display("FAIL d2_first_tick: got %0d, expected 1", first_tick); end
      n_checks++; if (gap_err != 0) begin n_fail++; $display("FAIL d2_tick_gap: got %0d bad gaps, expected 0", gap_err); end
      n_checks++; if (maxx != 24) begin n_fail++; $display("FAIL d2_max_pix_x: got %0d, expected 24", maxx); end
   endtask

   initial begin
      test_reset();
      test_pixel_hold();
      test_horizontal();
      test_vertical();
      test_mid_reset();
      test_div2();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
